// File: rtl/neuron_mac.sv
// neuron_mac
//   Multiply-accumulate front end of a single neuron. Accepts a stream of
//   signed (input, weight) pairs and forms a saturated running sum of their
//   products. After numWeight pairs the stored bias is added and a single
//   2*dataWidth pre-activation value is emitted with a one-cycle valid pulse.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_x       signed input sample
//   in_w       signed weight paired with in_x
//   in_valid   in_x/in_w are valid this cycle
//   in_ready   block accepts a pair this cycle (registered)
//   bias_in    signed bias, already aligned to product format
//   bias_valid load bias_in into the bias register
//   out        signed saturated pre-activation sum
//   out_valid  one-cycle pulse qualifying out
module neuron_mac #(
  parameter int dataWidth = 16,
  parameter int numWeight = 784
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [dataWidth-1:0]   in_x,
  input  logic signed [dataWidth-1:0]   in_w,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [2*dataWidth-1:0] bias_in,
  input  logic                          bias_valid,
  output logic signed [2*dataWidth-1:0] out,
  output logic                          out_valid
);

  localparam int SW    = 2 * dataWidth;
  localparam int CNT_W = $clog2(numWeight) + 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(numWeight);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(numWeight - 1);

  localparam logic signed [SW-1:0] SAT_MAX = {1'b0, {(SW-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {1'b1, {(SW-1){1'b0}}};

  typedef enum logic [1:0] {
    ACC  = 2'd0,
    BIAS = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]       cnt;
  logic                   accept;
  logic signed [SW-1:0]   mul_p1;
  logic                   vld_p1;
  logic signed [SW-1:0]   sum_p2;
  logic signed [SW-1:0]   bias_reg;

  // Two's-complement add that clamps instead of wrapping. Overflow is only
  // possible when both operands share a sign and the result's sign differs.
  function automatic logic signed [SW-1:0] sat_add(
    input logic signed [SW-1:0] a,
    input logic signed [SW-1:0] b
  );
    logic signed [SW-1:0] s;
    s = a + b;
    if (!a[SW-1] && !b[SW-1] && s[SW-1])
      return SAT_MAX;
    else if (a[SW-1] && b[SW-1] && !s[SW-1])
      return SAT_MIN;
    else
      return s;
  endfunction

  assign accept = in_valid && in_ready;

  // Handshake: count accepted pairs; the last pair of an evaluation drops
  // in_ready on its own accept edge so no extra pair can slip in.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      in_ready <= 1'b1;
    end else if (state == DONE) begin
      cnt      <= '0;
      in_ready <= 1'b1;
    end else if (accept) begin
      cnt <= cnt + CNT_W'(1);
      if (cnt == CNT_LAST)
        in_ready <= 1'b0;
    end
  end

  // Stage 1: full-width signed product of the accepted pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= accept;
      if (accept)
        mul_p1 <= SW'(in_x) * SW'(in_w);
    end
  end

  // Stage 2: saturated running sum, cleared during the turnaround cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_p2 <= '0;
    end else if (state == DONE) begin
      sum_p2 <= '0;
    end else if (vld_p1) begin
      sum_p2 <= sat_add(sum_p2, mul_p1);
    end
  end

  // Bias register loads in any state; at the BIAS edge the output stage reads
  // the pre-edge value, so a coincident load only affects the next evaluation.
  always_ff @(posedge clk) begin
    if (rst)
      bias_reg <= '0;
    else if (bias_valid)
      bias_reg <= bias_in;
  end

  // Stage 3: bias add and output register; out holds between evaluations.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else if (state == BIAS) begin
      out       <= sat_add(sum_p2, bias_reg);
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= ACC;
    else
      state <= state_nxt;
  end

  // Leave ACC once the final product (cnt already at numWeight) has been
  // folded into the sum, i.e. on the edge after the last accept.
  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (vld_p1 && (cnt == CNT_FULL)) state_nxt = BIAS;
      BIAS:    state_nxt = DONE;
      DONE:    state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

endmodule

// File: tb/tb_neuron_mac.sv
module tb_neuron_mac;

  localparam int DW = 16;
  localparam int NW = 4;

  logic                   clk;
  logic                   rst;
  logic signed [DW-1:0]   in_x;
  logic signed [DW-1:0]   in_w;
  logic                   in_valid;
  logic                   in_ready;
  logic signed [2*DW-1:0] bias_in;
  logic                   bias_valid;
  logic signed [2*DW-1:0] out;
  logic                   out_valid;

  neuron_mac #(.dataWidth(DW), .numWeight(NW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_x       (in_x),
    .in_w       (in_w),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .bias_in    (bias_in),
    .bias_valid (bias_valid),
    .out        (out),
    .out_valid  (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  int          pulses = 0;
  int          lowcnt = 0;
  int          pcyc [64];
  logic [31:0] pval [64];
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      pcyc[pulses & 63] = cyc;
      pval[pulses & 63] = out;
      pulses = pulses + 1;
    end
    if (in_ready === 1'b0) lowcnt = lowcnt + 1;
  end

  logic [15:0] px [16];
  logic [15:0] pw [16];
  bit          vpat [16];
  int          last_acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_bias(input logic [31:0] v);
    bias_in    = v;
    bias_valid = 1'b1;
    step();
    bias_valid = 1'b0;
  endtask

  task automatic fill(input logic [15:0] x, input logic [15:0] w);
    for (int i = 0; i < 16; i++) begin
      px[i] = x; pw[i] = w; vpat[i] = 1'b1;
    end
  endtask

  task automatic run_stream(input int npairs);
    int idx = 0;
    int slot = 0;
    int n = 0;
    bit acc;
    while (idx < npairs && n < 200) begin
      in_x     = px[idx];
      in_w     = pw[idx];
      in_valid = (slot < 16) ? vpat[slot] : 1'b1;
      acc      = in_valid && in_ready;
      step();
      if (acc) begin
        idx++;
        last_acc = cyc;
      end
      slot++;
      n++;
    end
    in_valid = 1'b0;
    check("stream_accepts", idx, npairs);
  endtask

  task automatic wait_pulse(input int base);
    int n = 0;
    while (pulses == base && n < 30) begin
      step();
      n++;
    end
    check("pulse_seen", (pulses > base), 1);
  endtask

  int base;
  int lbase;

  initial begin
    rst = 1'b1; in_x = '0; in_w = '0; in_valid = 1'b1;
    bias_in = '0; bias_valid = 1'b0;
    step();
    step();
    check("rst_out", out, 32'h0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    rst = 1'b0; in_valid = 1'b0;
    step();

    // Basic sum
    load_bias(32'h0001_0000);
    fill(16'h0100, 16'h0200);
    base = pulses; lbase = lowcnt;
    run_stream(4);
    wait_pulse(base);
    step(); step(); step();
    check("basic_out", pval[base & 63], 32'h0009_0000);
    check("basic_latency", pcyc[base & 63] - last_acc, 2);
    check("basic_one_pulse", pulses - base, 1);
    check("basic_ready_low", lowcnt - lbase, 3);
    check("basic_ready_back", in_ready, 1'b1);
    check("basic_out_hold", out, 32'h0009_0000);

    // Positive saturation
    load_bias(32'h7FFF_FFFF);
    fill(16'h7FFF, 16'h7FFF);
    base = pulses;
    run_stream(4);
    wait_pulse(base);
    check("pos_sat", pval[base & 63], 32'h7FFF_FFFF);

    // Negative saturation
    load_bias(32'h0);
    fill(16'h8000, 16'h7FFF);
    base = pulses;
    run_stream(4);
    wait_pulse(base);
    check("neg_sat", pval[base & 63], 32'h8000_0000);

    // Negative products without saturation
    fill(16'hFF00, 16'h0100);
    base = pulses;
    run_stream(4);
    wait_pulse(base);
    check("neg_sum", pval[base & 63], 32'hFFFC_0000);

    // Gapped valid, bias reload on the BIAS edge
    load_bias(32'd5);
    fill(16'd1, 16'd1);
    vpat[0] = 1; vpat[1] = 0; vpat[2] = 0; vpat[3] = 1;
    vpat[4] = 0; vpat[5] = 1; vpat[6] = 1;
    base = pulses;
    run_stream(4);
    step();
    bias_in = 32'd9; bias_valid = 1'b1;
    step();
    bias_valid = 1'b0;
    wait_pulse(base);
    check("gap_old_bias", pval[base & 63], 32'd9);
    fill(16'd1, 16'd1);
    base = pulses;
    run_stream(4);
    wait_pulse(base);
    check("gap_new_bias", pval[base & 63], 32'd13);

    // Back-to-back evaluations with in_valid held high
    load_bias(32'h10);
    fill(16'd2, 16'd3);
    for (int i = 4; i < 8; i++) begin
      px[i] = 16'hFFFB; pw[i] = 16'd7;
    end
    base = pulses;
    run_stream(8);
    wait_pulse(base + 1);
    step(); step(); step();
    check("b2b_pulses", pulses - base, 2);
    check("b2b_spacing", pcyc[(base + 1) & 63] - pcyc[base & 63], 7);
    check("b2b_first", pval[base & 63], 32'd40);
    check("b2b_second", pval[(base + 1) & 63], 32'hFFFF_FF84);

    // Reset mid-accumulation (also clears the 0x10 bias)
    fill(16'h0100, 16'h0100);
    base = pulses;
    run_stream(2);
    rst = 1'b1; in_valid = 1'b1;
    step();
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_out", out, 32'h0);
    rst = 1'b0; in_valid = 1'b0;
    step();
    check("post_rst_out_valid", out_valid, 1'b0);
    run_stream(4);
    wait_pulse(base);
    step(); step();
    check("rst_fresh_sum", pval[base & 63], 32'h0004_0000);
    check("rst_one_pulse", pulses - base, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/neuron_mac.md
# neuron_mac

Multiply-accumulate front end of a single neuron. It consumes a stream of (input, weight) pairs and forms a saturated running sum of their signed products. After numWeight pairs it adds a stored bias and emits one 2*dataWidth pre-activation value with a single-cycle valid pulse. That value is the exact format the downstream activation stage (ReLU/sigmoid) takes on its `x` input.

## Interface
Parameters:
- dataWidth, 16, width of input, weight and the activation output; the pre-activation sum is 2*dataWidth.
- numWeight, 784, number of (input, weight) pairs per neuron evaluation; must be ≥ 1.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_x  input  dataWidth  signed input sample.
- in_w  input  dataWidth  signed weight paired with in_x.
- in_valid  input  1  in_x/in_w are valid.
- in_ready  output  1  the block can accept a pair this cycle.
- bias_in  input  2*dataWidth  signed bias, already aligned to product format.
- bias_valid  input  1  load bias_in into the bias register.
- out  output  2*dataWidth  signed saturated pre-activation sum.
- out_valid  output  1  one-cycle pulse qualifying out.

## Operation
- Handshake: a pair is accepted at an edge where in_valid & in_ready = 1. Pairs are never dropped or duplicated. in_valid may have gaps.
- Stage 1: at each accept, mul <= $signed(in_x) * $signed(in_w), full 2*dataWidth, and mul_valid <= 1. Otherwise mul_valid <= 0.
- Stage 2: when mul_valid = 1, sum <= sat_add(sum, mul).
- sat_add(a,b): compute a+b in 2*dataWidth.
  - If a and b are both non-negative and the result is negative, the result is 0x7FF…F.
  - If a and b are both negative and the result is non-negative, the result is 0x800…0.
  - Otherwise the result is the wrapped sum.
- Counter cnt, $clog2(numWeight)+1 bits, increments per accepted pair.
- State machine:
  - ACC: in_ready = 1. The pair that brings cnt to numWeight drops in_ready at that same edge. After that pair's product is added to sum, move to BIAS.
  - BIAS: for one cycle, out <= sat_add(sum, bias_reg) and out_valid <= 1. Move to DONE.
  - DONE: for one cycle, out_valid <= 0, sum <= 0, cnt <= 0, in_ready <= 1. Move to ACC.
- bias_reg loads on any edge with bias_valid = 1, in any state. If the load coincides with the BIAS edge, the pre-edge (old) bias_reg is used.
- out holds its last value until the next BIAS edge.
- Reset, at any time including mid-accumulation:
  - out = 0, out_valid = 0, in_ready = 1.
  - sum = 0, mul = 0, mul_valid = 0, cnt = 0, bias_reg = 0, state = ACC.
  - Any partial accumulation is discarded. A pair presented during rst is not accepted.

## Timing
- Let edge k be the edge that accepts the last (numWeight-th) pair.
  - k: mul registered; in_ready falls.
  - k+1: last product added to sum; state becomes BIAS.
  - k+2: out valid, out_valid = 1.
  - k+3: out_valid = 0, in_ready = 1.
  - k+4: earliest acceptance of the next neuron's first pair.
- Latency is 2 edges from the last accept to out_valid.
- Throughput is one pair per cycle within an evaluation, plus a 3-cycle turnaround between evaluations.
- numWeight = 1: the same sequence with k being the only accept.
- in_ready is registered with no combinational path from in_valid.

## Test plan
- Basic sum (dataWidth=16, numWeight=4):
  - Stimulus: bias 0x00010000; four back-to-back pairs x=0x0100, w=0x0200.
  - Response: out=0x00090000 with a single out_valid pulse 2 edges after the 4th accept; in_ready low for exactly 3 cycles.
- Positive saturation: four pairs x=0x7FFF, w=0x7FFF, bias 0x7FFFFFFF → out=0x7FFFFFFF.
- Negative saturation and sign:
  - Four pairs x=0x8000, w=0x7FFF, bias 0 → out=0x80000000.
  - Pairs x=0xFF00, w=0x0100 ×4 → out=0xFFFC0000.
- Gapped valid and bias timing:
  - Stimulus: in_valid toggles 1,0,0,1,0,1,1 with x=1, w=1, bias 5; bias_valid with bias 9 asserted on the BIAS edge.
  - Response: out=0x00000009 (uses old bias 5); the next evaluation uses 9.
- Back-to-back evaluations: present 8 pairs continuously with in_valid held high → exactly two out_valid pulses, 7 cycles apart, with independent sums.
- Reset mid-operation:
  - Stimulus: after 2 of 4 pairs (x=w=0x0100), assert rst for one cycle, then send 4 fresh pairs x=w=0x0100 with bias 0.
  - Response: out=0x00040000 (not 0x00060000); out_valid stays 0 during and immediately after reset.
